// File: rtl/bet_slot_bank.sv
`default_nettype none
// ============================================================================
//  Module   : bet_slot_bank
//  Purpose  : Edge-detected bet capture buffer with undo, spin lock and
//             payout clear for the roulette table.
//  Revision : 1.0  initial release
// ============================================================================
module bet_slot_bank #(
    parameter int                    NUM_SLOTS = 12,
    parameter int                    OPCODE_W  = 6,
    parameter int                    COLOR_W   = 2,
    parameter logic [OPCODE_W-1:0]   SPIN_OP   = 6'b111110,
    parameter logic [OPCODE_W-1:0]   CANCEL_OP = 6'b111111,
    localparam int                   SLOT_W    = COLOR_W + OPCODE_W,
    localparam int                   CNT_W     = $clog2(NUM_SLOTS + 1),
    localparam int                   IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           key_valid,
    input  logic [OPCODE_W-1:0]            key_opcode,
    input  logic [2:0]                     color_in,
    input  logic                           spin_done,
    input  logic [IDX_W-1:0]               rd_index,
    output logic [SLOT_W-1:0]              rd_data,
    output logic [NUM_SLOTS*SLOT_W-1:0]    slots_flat,
    output logic [NUM_SLOTS-1:0]           slot_valid,
    output logic [CNT_W-1:0]               bet_count,
    output logic                           full,
    output logic                           spin_check,
    output logic                           spin_req,
    output logic                           bet_accept,
    output logic                           bet_reject
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_SLOTS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic              key_valid_q;
    logic              ev;
    logic              chip_present;
    logic              is_spin;
    logic              is_cancel;
    logic              do_store;
    logic              do_cancel;
    logic              do_clear;
    logic              accept_next;
    logic              reject_next;
    logic              spin_req_next;
    logic [SLOT_W-1:0] store_data;

    assign ev           = key_valid & ~key_valid_q;
    assign chip_present = (color_in != 3'b000);
    assign is_spin      = (key_opcode == SPIN_OP);
    assign is_cancel    = (key_opcode == CANCEL_OP);
    assign store_data   = {color_in[COLOR_W-1:0], key_opcode};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_OPEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        do_store      = 1'b0;
        do_cancel     = 1'b0;
        do_clear      = 1'b0;
        accept_next   = 1'b0;
        reject_next   = 1'b0;
        spin_req_next = 1'b0;
        case (state)
            ST_OPEN: begin
                if (ev) begin
                    if (is_cancel) begin
                        if (bet_count != '0) begin
                            do_cancel   = 1'b1;
                            accept_next = 1'b1;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end else if (is_spin) begin
                        if (bet_count != '0) begin
                            state_next    = ST_LOCKED;
                            spin_req_next = 1'b1;
                            accept_next   = 1'b1;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end else if (chip_present && (bet_count < MAX_CNT)) begin
                        do_store    = 1'b1;
                        accept_next = 1'b1;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // spin_done wins over a simultaneous key event
                if (spin_done) begin
                    do_clear   = 1'b1;
                    state_next = ST_OPEN;
                end
                reject_next = ev;
            end
            default: begin
                state_next = ST_OPEN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_valid_q <= 1'b0;
            bet_count   <= '0;
            spin_req    <= 1'b0;
            bet_accept  <= 1'b0;
            bet_reject  <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
            spin_req    <= spin_req_next;
            bet_accept  <= accept_next;
            bet_reject  <= reject_next;
            if (do_clear) begin
                bet_count <= '0;
            end else if (do_store) begin
                bet_count <= bet_count + ONE;
            end else if (do_cancel) begin
                bet_count <= bet_count - ONE;
            end
        end
    end

    // Slot i is written when it is the next free slot and cleared when it is the newest bet
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        localparam logic [CNT_W-1:0] POS      = CNT_W'(i);
        localparam logic [CNT_W-1:0] POS_NEXT = CNT_W'(i + 1);

        logic [SLOT_W-1:0] data;
        logic              valid;

        always_ff @(posedge clock) begin
            if (reset || do_clear) begin
                data  <= '0;
                valid <= 1'b0;
            end else if (do_store && (bet_count == POS)) begin
                data  <= store_data;
                valid <= 1'b1;
            end else if (do_cancel && (bet_count == POS_NEXT)) begin
                data  <= '0;
                valid <= 1'b0;
            end
        end

        assign slots_flat[i*SLOT_W +: SLOT_W] = data;
        assign slot_valid[i]                  = valid;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_index == IDX_W'(i)) begin
                rd_data = slots_flat[i*SLOT_W +: SLOT_W];
            end
        end
    end

    assign full       = (bet_count == MAX_CNT);
    assign spin_check = (state == ST_LOCKED) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_bet_slot_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bet_slot_bank
//  Purpose  : Self-checking bench for bet_slot_bank against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bet_slot_bank;

    localparam int NS = 12;
    localparam int SW = 8;
    localparam logic [5:0] SPIN   = 6'b111110;
    localparam logic [5:0] CANCEL = 6'b111111;

    logic            clock = 1'b0;
    logic            reset;
    logic            key_valid;
    logic [5:0]      key_opcode;
    logic [2:0]      color_in;
    logic            spin_done;
    logic [3:0]      rd_index;
    logic [SW-1:0]   rd_data;
    logic [NS*SW-1:0] slots_flat;
    logic [NS-1:0]   slot_valid;
    logic [3:0]      bet_count;
    logic            full;
    logic            spin_check;
    logic            spin_req;
    logic            bet_accept;
    logic            bet_reject;

    bet_slot_bank dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_opcode (key_opcode),
        .color_in   (color_in),
        .spin_done  (spin_done),
        .rd_index   (rd_index),
        .rd_data    (rd_data),
        .slots_flat (slots_flat),
        .slot_valid (slot_valid),
        .bet_count  (bet_count),
        .full       (full),
        .spin_check (spin_check),
        .spin_req   (spin_req),
        .bet_accept (bet_accept),
        .bet_reject (bet_reject)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bank is a stack of bets
    logic [7:0] bets[$];
    bit         m_locked;
    bit         m_kvq;
    bit         m_acc;
    bit         m_rej;
    bit         m_sreq;

    always @(posedge clock) begin
        bit ev;
        if (reset) begin
            bets.delete();
            m_locked = 1'b0;
            m_kvq    = 1'b0;
            m_acc    = 1'b0;
            m_rej    = 1'b0;
            m_sreq   = 1'b0;
        end else begin
            ev     = key_valid && !m_kvq;
            m_kvq  = key_valid;
            m_acc  = 1'b0;
            m_rej  = 1'b0;
            m_sreq = 1'b0;
            if (m_locked) begin
                if (spin_done) begin
                    bets.delete();
                    m_locked = 1'b0;
                end
                if (ev) m_rej = 1'b1;
            end else if (ev) begin
                if (key_opcode == CANCEL) begin
                    if (bets.size() > 0) begin
                        void'(bets.pop_back());
                        m_acc = 1'b1;
                    end else m_rej = 1'b1;
                end else if (key_opcode == SPIN) begin
                    if (bets.size() > 0) begin
                        m_locked = 1'b1;
                        m_sreq   = 1'b1;
                        m_acc    = 1'b1;
                    end else m_rej = 1'b1;
                end else if (color_in != 3'b000 && bets.size() < NS) begin
                    bets.push_back({color_in[1:0], key_opcode});
                    m_acc = 1'b1;
                end else m_rej = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic [NS*SW-1:0] e_flat;
            logic [SW-1:0]    e_rd;
            e_flat = '0;
            for (int i = 0; i < bets.size(); i++) e_flat[i*SW +: SW] = bets[i];
            e_rd = (int'(rd_index) < bets.size()) ? bets[rd_index] : 8'h00;
            check("bet_count",  128'(bet_count),  128'(bets.size()));
            check("slot_valid", 128'(slot_valid), 128'((1 << bets.size()) - 1));
            check("slots_flat", 128'(slots_flat), 128'(e_flat));
            check("rd_data",    128'(rd_data),    128'(e_rd));
            check("full",       128'(full),       128'(bets.size() == NS));
            check("spin_check", 128'(spin_check), 128'(m_locked && !reset));
            check("spin_req",   128'(spin_req),   128'(m_sreq));
            check("bet_accept", 128'(bet_accept), 128'(m_acc));
            check("bet_reject", 128'(bet_reject), 128'(m_rej));
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic press(input logic [5:0] op, input logic [2:0] col,
                         output logic acc, output logic rej);
        key_valid  = 1'b1;
        key_opcode = op;
        color_in   = col;
        tick();
        acc = bet_accept;
        rej = bet_reject;
        key_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic a, r;
        int   n_acc;
        reset = 1'b1; key_valid = 1'b0; key_opcode = '0; color_in = '0;
        spin_done = 1'b0; rd_index = '0;
        tick();
        chk_en = 1'b1;
        do_reset();
        check("rst_count", 128'(bet_count), 128'(0));
        check("rst_spin_check", 128'(spin_check), 128'(0));

        // Held key produces one event
        key_valid = 1'b1; key_opcode = 6'd17; color_in = 3'b001;
        n_acc = 0;
        repeat (5) begin
            tick();
            if (bet_accept) n_acc++;
        end
        key_valid = 1'b0;
        tick();
        check("hold_accepts", 128'(n_acc), 128'(1));
        check("hold_slot0", 128'(slots_flat[7:0]), 128'(8'h51));
        check("hold_count", 128'(bet_count), 128'(1));
        check("hold_valid", 128'(slot_valid), 128'(12'h001));

        // Fill to capacity
        do_reset();
        for (int i = 0; i < NS; i++) press(6'(i + 1), 3'b010, a, r);
        check("fill_full", 128'(full), 128'(1));
        press(6'd40, 3'b010, a, r);
        check("over_reject", 128'(r), 128'(1));
        check("over_slot11", 128'(slots_flat[95:88]), 128'(8'h8C));
        check("over_count", 128'(bet_count), 128'(12));

        // Cancel then reuse slot
        do_reset();
        for (int i = 0; i < 3; i++) press(6'(i + 20), 3'b001, a, r);
        press(CANCEL, 3'b000, a, r);
        check("cancel_accept", 128'(a), 128'(1));
        check("cancel_count", 128'(bet_count), 128'(2));
        check("cancel_slot2", 128'(slots_flat[23:16]), 128'(0));
        press(6'd5, 3'b011, a, r);
        check("reuse_slot2", 128'(slots_flat[23:16]), 128'(8'hC5));

        // No chip, and spin with empty bank
        press(6'd7, 3'b000, a, r);
        check("nochip_reject", 128'(r), 128'(1));
        check("nochip_count", 128'(bet_count), 128'(3));
        do_reset();
        press(SPIN, 3'b001, a, r);
        check("empty_spin_reject", 128'(r), 128'(1));
        check("empty_spin_check", 128'(spin_check), 128'(0));

        // Spin, locked reject, payout clear
        press(6'd1, 3'b001, a, r);
        press(6'd2, 3'b010, a, r);
        key_valid = 1'b1; key_opcode = SPIN;
        tick();
        check("spin_req_pulse", 128'(spin_req), 128'(1));
        check("spin_check_hi", 128'(spin_check), 128'(1));
        key_valid = 1'b0;
        tick();
        press(6'd3, 3'b001, a, r);
        check("locked_reject", 128'(r), 128'(1));
        check("locked_count", 128'(bet_count), 128'(2));
        spin_done = 1'b1;
        tick();
        spin_done = 1'b0;
        check("done_count", 128'(bet_count), 128'(0));
        check("done_flat", 128'(slots_flat), 128'(0));
        check("done_check", 128'(spin_check), 128'(0));

        // Event and spin_done together
        press(6'd4, 3'b001, a, r);
        press(SPIN, 3'b000, a, r);
        key_valid = 1'b1; key_opcode = 6'd9; color_in = 3'b001; spin_done = 1'b1;
        tick();
        key_valid = 1'b0; spin_done = 1'b0;
        check("both_reject", 128'(bet_reject), 128'(1));
        check("both_cleared", 128'(bet_count), 128'(0));
        tick();

        // Reset while locked
        press(6'd8, 3'b010, a, r);
        press(SPIN, 3'b000, a, r);
        reset = 1'b1;
        #1;
        check("rst_lock_check", 128'(spin_check), 128'(0));
        tick();
        reset = 1'b0;
        check("rst_lock_count", 128'(bet_count), 128'(0));
        check("rst_lock_flat", 128'(slots_flat), 128'(0));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int sel;
            reset     = ($urandom_range(0, 299) == 0);
            key_valid = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            key_opcode = (sel == 0) ? CANCEL : (sel == 1) ? SPIN : 6'($urandom_range(0, 61));
            color_in  = 3'($urandom_range(0, 7));
            spin_done = ($urandom_range(0, 11) == 0);
            rd_index  = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0; key_valid = 1'b0; spin_done = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
